// File: rtl/yarp_mem_arbiter.sv
// Arbitrates the I-fetch and load/store ports onto one memory port.
// Ports: i_* fetch side, d_* data side, mem_* memory side, busy_o.
module yarp_mem_arbiter #(
  parameter int         ADDR_W       = 32,
  parameter int         STARVE_LIMIT = 4,
  parameter logic [1:0] WORD_EN      = 2'b10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [31:0]       i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_wr_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [1:0]        d_byte_en_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [1:0]        mem_byte_en_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [CW-1:0]       starve_q, starve_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [1:0]          mem_be_q, mem_be_d;
  logic [31:0]         i_rdata_q, i_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                i_rvalid_q, i_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic                pick_d;
  logic                gnt;

  // D wins ties unless I has been passed over too often.
  assign pick_d = d_req_i &
                  ~(i_req_i & (starve_q == LIMIT));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!i_req_i) starve_d = '0;
        if (d_req_i || i_req_i) begin
          state_d   = REQ;
          mem_req_d = 1'b1;
          owner_d   = pick_d;
          if (pick_d) begin
            mem_wr_d    = d_wr_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
            mem_be_d    = d_byte_en_i;
            if (i_req_i && starve_q != LIMIT)
              starve_d = starve_q + 1'b1;
          end else begin
            mem_wr_d    = 1'b0;
            mem_addr_d  = i_addr_i;
            mem_wdata_d = '0;
            mem_be_d    = WORD_EN;
            starve_d    = '0;
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = mem_wr_q ? IDLE : RESP;
        end
      end
      RESP: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (owner_q) begin
            d_rdata_d  = mem_rdata_i;
            d_rvalid_d = 1'b1;
          end else begin
            i_rdata_d  = mem_rdata_i;
            i_rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

  // Grant is passed straight through so the owner sees it in the
  // same cycle the memory accepts.
  assign gnt           = (state_q == REQ) & mem_gnt_i;
  assign i_gnt_o       = gnt & ~owner_q;
  assign d_gnt_o       = gnt & owner_q;
  assign i_rvalid_o    = i_rvalid_q;
  assign d_rvalid_o    = d_rvalid_q;
  assign i_rdata_o     = i_rdata_q;
  assign d_rdata_o     = d_rdata_q;
  assign mem_req_o     = mem_req_q;
  assign mem_wr_o      = mem_wr_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign mem_byte_en_o = mem_be_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Scoreboard bench for yarp_mem_arbiter with a scripted memory.
// Stimulus pushes expected pulses; a monitor pops and compares.
module tb_yarp_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req_i = 1'b0;
  logic [31:0] i_addr_i = '0;
  logic        i_gnt_o, i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_wr_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic [1:0]  d_byte_en_i = '0;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_wr_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [1:0]  mem_byte_en_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  yarp_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i),
    .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o),
    .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_wr_i(d_wr_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_byte_en_i(d_byte_en_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_byte_en_o(mem_byte_en_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  localparam int K_IG = 0;
  localparam int K_DG = 1;
  localparam int K_IR = 2;
  localparam int K_DR = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, got, exp);
  endtask

  task automatic push(input int k, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'h1000: return 32'h00500093;
      32'h2000: return 32'h12345678;
      32'h3000: return 32'hCAFEF00D;
      default:  return 32'hBAD0BAD0;
    endcase
  endfunction

  // Scripted memory: grants after gnt_delay waiting cycles,
  // returns load data rv_delay cycles after the grant.
  int          gnt_delay = 0;
  int          rv_delay = 2;
  int          wcnt = 0;
  int          rvcnt = 0;
  int          spur_req = 0;
  int          spur_ack = 0;
  logic [31:0] rv_data = '0;

  initial begin
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (rvcnt > 0) begin
        rvcnt--;
        if (rvcnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = rv_data;
        end
      end
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h5A5A5A5A;
      end
      if (mem_req_o === 1'b1) begin
        if (wcnt >= gnt_delay) begin
          mem_gnt_i = 1'b1;
          wcnt = 0;
          if (!mem_wr_o) begin
            rvcnt = rv_delay;
            rv_data = mem_fn(mem_addr_o);
          end
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  task automatic pop_chk(input int k, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_event: got kind %0d data %0h, expected none",
               k, d);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      if (k >= K_IR) chk("event_rdata", d, e.data);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset_n === 1'b1) begin
        if (i_gnt_o || d_gnt_o)
          chk("gnt_exclusive", i_gnt_o & d_gnt_o, 0);
        if (i_rvalid_o || d_rvalid_o)
          chk("rvalid_exclusive", i_rvalid_o & d_rvalid_o, 0);
        if (i_gnt_o) pop_chk(K_IG, 0);
        if (d_gnt_o) pop_chk(K_DG, 0);
        if (i_rvalid_o) pop_chk(K_IR, i_rdata_o);
        if (d_rvalid_o) pop_chk(K_DR, d_rdata_o);
      end
    end
  end

  task automatic samp();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_for(input int which, input string name);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      samp();
      case (which)
        0: hit = i_gnt_o;
        1: hit = d_gnt_o;
        default: hit = mem_req_o;
      endcase
    end
    if (!hit) begin
      n_chk++;
      $display("FAIL timeout_%s: got no event, expected one", name);
    end
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) samp();
    chk(name, exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_mem_req"}, mem_req_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_rdata"}, {i_rdata_o, d_rdata_o}, 0);
    chk({tag, "_misc"},
        {i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o,
         mem_wr_o, mem_wdata_o, mem_byte_en_o}, 0);
  endtask

  task automatic i_read(input logic [31:0] a, input logic [31:0] d);
    push(K_IG, 0);
    push(K_IR, d);
    i_addr_i = a;
    i_req_i = 1'b1;
    if (!i_gnt_o) wait_for(0, "i_gnt");
    samp();
    i_req_i = 1'b0;
  endtask

  int nreq, ngr, t_rv, t_req;
  bit drop_i, drop_d, got;

  initial begin
    reset_n = 1'b0;
    samp();
    samp();
    chk_zero("reset");
    reset_n = 1'b1;

    // single I read
    gnt_delay = 0;
    rv_delay = 2;
    samp();
    push(K_IG, 0);
    push(K_IR, 32'h00500093);
    i_addr_i = 32'h1000;
    i_req_i = 1'b1;
    wait_for(2, "i_mem_req");
    chk("i_mem_addr", mem_addr_o, 32'h1000);
    chk("i_byte_en", mem_byte_en_o, 2'b10);
    chk("i_wr_wdata", {mem_wr_o, mem_wdata_o}, 0);
    if (!i_gnt_o) wait_for(0, "i_gnt");
    samp();
    i_req_i = 1'b0;
    drain("i_read_drain");

    // D store, grant after 3 waiting cycles
    gnt_delay = 3;
    push(K_DG, 0);
    d_wr_i = 1'b1;
    d_addr_i = 32'h2004;
    d_wdata_i = 32'hDEADBEEF;
    d_byte_en_i = 2'b00;
    d_req_i = 1'b1;
    wait_for(2, "st_mem_req");
    nreq = 0;
    for (int c = 0; c < 20 && mem_req_o; c++) begin
      nreq++;
      chk("st_fields",
          {mem_wr_o, mem_addr_o, mem_wdata_o, mem_byte_en_o},
          {1'b1, 32'h2004, 32'hDEADBEEF, 2'b00});
      if (d_gnt_o) break;
      samp();
    end
    chk("st_req_cycles", nreq, 4);
    samp();
    chk("st_idle_after", {busy_o, mem_req_o}, 0);
    d_req_i = 1'b0;
    d_wr_i = 1'b0;
    drain("store_drain");

    // both requesting: D,D,D,D,I,D,D,D,D,I then a final D
    gnt_delay = 0;
    rv_delay = 1;
    for (int g = 0; g < 11; g++) begin
      if (g == 4 || g == 9) begin
        push(K_IG, 0);
        push(K_IR, 32'h00500093);
      end else begin
        push(K_DG, 0);
        push(K_DR, 32'h12345678);
      end
    end
    i_addr_i = 32'h1000;
    d_addr_i = 32'h2000;
    d_byte_en_i = 2'b10;
    i_req_i = 1'b1;
    d_req_i = 1'b1;
    ngr = 0;
    drop_i = 1'b0;
    drop_d = 1'b0;
    for (int c = 0; c < 400 && !drop_d; c++) begin
      samp();
      if (drop_i) begin
        i_req_i = 1'b0;
        drop_i = 1'b0;
      end
      if (i_gnt_o) begin
        ngr++;
        if (ngr == 10) drop_i = 1'b1;
      end
      if (d_gnt_o) begin
        ngr++;
        if (ngr == 11) drop_d = 1'b1;
      end
    end
    samp();
    d_req_i = 1'b0;
    i_req_i = 1'b0;
    chk("starve_grants", ngr, 11);
    drain("starve_drain");

    // I arrives while D load sits in RESP
    rv_delay = 3;
    push(K_DG, 0);
    push(K_DR, 32'h12345678);
    push(K_IG, 0);
    push(K_IR, 32'hCAFEF00D);
    d_addr_i = 32'h2000;
    d_req_i = 1'b1;
    wait_for(1, "d_gnt");
    samp();
    d_req_i = 1'b0;
    i_addr_i = 32'h3000;
    i_req_i = 1'b1;
    t_rv = -100;
    t_req = -1;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      samp();
      if (d_rvalid_o) t_rv = cyc;
      if (mem_req_o && mem_addr_o == 32'h3000 && t_req < 0)
        t_req = cyc;
      if (i_gnt_o) got = 1'b1;
    end
    chk("wait_i_gnt", got, 1);
    chk("i_req_gap", t_req - t_rv, 1);
    samp();
    i_req_i = 1'b0;
    drain("overlap_drain");

    // spurious rvalid in IDLE and in REQ
    gnt_delay = 3;
    rv_delay = 2;
    spur_req++;
    samp();
    samp();
    chk("spur_idle", {busy_o, mem_req_o}, 0);
    push(K_IG, 0);
    push(K_IR, 32'h00500093);
    i_addr_i = 32'h1000;
    i_req_i = 1'b1;
    wait_for(2, "spur_mem_req");
    spur_req++;
    samp();
    samp();
    chk("spur_req", {busy_o, mem_req_o}, 2'b11);
    if (!i_gnt_o) wait_for(0, "spur_i_gnt");
    samp();
    i_req_i = 1'b0;
    drain("spur_drain");

    // reset in RESP discards response
    gnt_delay = 0;
    rv_delay = 3;
    push(K_DG, 0);
    d_addr_i = 32'h2000;
    d_byte_en_i = 2'b01;
    d_req_i = 1'b1;
    wait_for(1, "rst_d_gnt");
    samp();
    d_req_i = 1'b0;
    chk("rst_in_resp", busy_o, 1);
    reset_n = 1'b0;
    #1;
    chk_zero("midreset");
    samp();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) samp();
    chk("post_rst", {busy_o, d_rdata_o}, 0);
    i_read(32'h1000, 32'h00500093);
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
